// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding and
// shift-direction constants used by the sequencer and its shift stage.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Single-step logical shifter: shifts a WIDTH-bit word by one position,
// filling with zero, and reports the bit that falls off the end.
//   i_data  : operand
//   i_dir   : DIR_LEFT / DIR_RIGHT
//   o_data  : shifted word
//   o_out   : bit shifted out (MSB for left, LSB for right)
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_data,
    output logic             o_out
);

    // One-position logical shift in the requested direction.
    always_comb begin
        o_data = {WIDTH{1'b0}};
        o_out  = 1'b0;
        if (i_dir == DIR_RIGHT) begin
            o_data = {1'b0, i_data[WIDTH-1:1]};
            o_out  = i_data[0];
        end else begin
            o_data = {i_data[WIDTH-2:0], 1'b0};
            o_out  = i_data[WIDTH-1];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit logical shifter front end. Accepts an operand, direction and
// shift amount over valid/ready, applies one bit of shift per clock
// through shift_step, then holds the result until the consumer takes it.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : request present        in_ready  : can accept (IDLE only)
//   in_data    : operand                in_dir    : 0 left, 1 right
//   in_amt     : shift count (values >= WIDTH saturate to WIDTH)
//   out_valid  : result held (DONE)     out_ready : consumer takes result
//   out_data   : shifted result         out_last  : last bit shifted out
//   busy       : FSM not in IDLE
// Every output is decoded from state or taken straight from a register.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic [AW-1:0]    in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam logic [AW-1:0] CNT_SAT  = AW'(WIDTH);
    localparam logic [AW-1:0] CNT_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};

    state_e           r_state;
    state_e           w_next_state;
    logic [WIDTH-1:0] r_data;
    logic             r_dir;
    logic             r_last;
    logic [AW-1:0]    r_cnt;
    logic [AW-1:0]    w_eff_cnt;
    logic [WIDTH-1:0] w_step_data;
    logic             w_step_out;
    logic             w_accept;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_data (r_data),
        .i_dir  (r_dir),
        .o_data (w_step_data),
        .o_out  (w_step_out)
    );

    // Requests are only taken in IDLE; in_ready is IDLE itself.
    assign w_accept = in_valid && (r_state == IDLE);

    // Clamp the requested amount so oversize shifts run exactly WIDTH steps.
    always_comb begin
        w_eff_cnt = CNT_ZERO;
        if (in_amt >= CNT_SAT) begin
            w_eff_cnt = CNT_SAT;
        end else begin
            w_eff_cnt = in_amt;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_eff_cnt == CNT_ZERO) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = SHIFT;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_ONE) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand, direction, last-bit and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= {WIDTH{1'b0}};
            r_dir  <= DIR_LEFT;
            r_last <= 1'b0;
            r_cnt  <= CNT_ZERO;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data <= in_data;
                        r_dir  <= in_dir;
                        r_last <= 1'b0;
                        r_cnt  <= w_eff_cnt;
                    end
                end
                SHIFT: begin
                    // r_cnt is at least one here, so this never wraps.
                    r_data <= w_step_data;
                    r_last <= w_step_out;
                    r_cnt  <= r_cnt - CNT_ONE;
                end
                DONE: begin
                    r_data <= r_data;
                end
                default: begin
                    r_cnt <= CNT_ZERO;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_data;
    assign out_last  = r_last;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    localparam int WIDTH = 4;
    localparam int AW    = 3;

    typedef struct {
        int data;
        int last;
        int due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_dir = 1'b0;
    logic [AW-1:0]    in_amt = '0;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    logic rand_or  = 1'b0;
    logic or_force = 1'b1;
    logic rnd_bit  = 1'b1;
    assign out_ready = rand_or ? rnd_bit : or_force;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    shift_sequencer #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: shift as a whole number, n = min(amt, WIDTH).
    function automatic exp_t model(input int d, input int dir, input int amt, input int t);
        exp_t e;
        int   n;
        int   mask;
        n    = (amt >= WIDTH) ? WIDTH : amt;
        mask = (1 << WIDTH) - 1;
        if (n == 0) begin
            e.data = d;
            e.last = 0;
        end else if (dir == 0) begin
            e.data = (d << n) & mask;
            e.last = (d >> (WIDTH - n)) & 1;
        end else begin
            e.data = d >> n;
            e.last = (d >> (n - 1)) & 1;
        end
        e.due = t + 1 + n;
        return e;
    endfunction

    // Monitor: pop on each new result, then watch it stay stable while held.
    logic             prev_valid = 1'b0;
    logic [WIDTH-1:0] held_data;
    logic             held_last;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else if (out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", int'(out_data), e.data);
                chk("out_last", int'(out_last), e.last);
                chk("latency", cyc, e.due);
            end
            held_data  = out_data;
            held_last  = out_last;
            prev_valid = 1'b1;
        end else if (out_valid) begin
            chk("hold_data", int'(out_data), int'(held_data));
            chk("hold_last", int'(out_last), int'(held_last));
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("idle_timeout", 0, 1);
    endtask

    // Issue one request at a negedge in IDLE; it is taken at the next edge.
    task automatic send(input int d, input int dir, input int amt);
        @(negedge clk);
        wait_idle();
        in_valid = 1'b1;
        in_data  = WIDTH'(d);
        in_dir   = dir[0];
        in_amt   = AW'(amt);
        exp_q.push_back(model(d, dir, amt, cyc));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Directed cases.
        send(4'b1011, 0, 2);
        @(negedge clk);
        chk("busy_after_accept", int'(busy), 1);
        chk("ready_after_accept", int'(in_ready), 0);
        send(4'b1011, 1, 1);
        send(4'b1001, 0, 0);
        send(4'b0001, 0, 7);
        send(4'b1000, 1, 4);
        send(4'b0110, 1, 5);

        // Backpressure with an ignored in_valid during DONE.
        @(negedge clk);
        wait_idle();
        or_force = 1'b0;
        send(4'b1011, 1, 1);
        begin
            int k;
            k = 0;
            while (!out_valid && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("bp_reach_done", int'(out_valid), 1);
        end
        in_valid = 1'b1;
        in_data  = 4'hF;
        in_amt   = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        in_valid = 1'b0;
        or_force = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", int'(in_ready), 1);
        chk("bp_release_valid", int'(out_valid), 0);

        // Reset in the second SHIFT cycle of a 3-step request.
        send(4'b0110, 0, 3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        exp_q.delete();
        // in_valid together with rst must not be taken.
        in_valid = 1'b1;
        in_data  = 4'h5;
        in_amt   = 3'd1;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        chk_reset_vals("rst_and_valid");
        send(4'b0011, 0, 1);

        // Randomized traffic with random backpressure.
        rand_or = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)));
        end

        // Drain.
        rand_or = 1'b0;
        begin
            int k;
            k = 0;
            while ((exp_q.size() != 0 || busy) && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("drain_queue_empty", exp_q.size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-bit logical shifter front end. Accepts a WIDTH-bit operand, a direction and a shift amount over a valid/ready handshake. Applies the shift one bit per clock through a single-step logical shift stage, then holds the result until it is consumed. It sits directly upstream of the one-bit logical shift datapath, drives that datapath's input, and consumes its output each cycle.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (≥2)
- AW, $clog2(WIDTH)+1, width of the shift-amount field

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  request present
- in_ready  output  1  sequencer can accept a request
- in_data  input  WIDTH  operand
- in_dir  input  1  0 = logical left, 1 = logical right
- in_amt  input  AW  requested shift count
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_data  output  WIDTH  shifted result
- out_last  output  1  last bit shifted out (0 if no shift performed)
- busy  output  1  high whenever the FSM is not in IDLE

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: load data_q←in_data, dir_q←in_dir, last_q←0, cnt←min(in_amt, WIDTH).
  - Next state is SHIFT if the effective count is nonzero, else DONE.
- SHIFT, each cycle:
  - data_q←step(data_q, dir_q).
  - last_q←bit shifted out: data_q[WIDTH-1] for left, data_q[0] for right.
  - cnt←cnt−1.
  - When cnt==1, next state is DONE.
- DONE:
  - out_valid=1; out_data=data_q and out_last=last_q are held stable.
  - On out_ready, next state is IDLE.
- in_ready is high only in IDLE. There is no overlap between result hold and a new acceptance. in_valid is ignored outside IDLE.
- Shift-in bit is always 0 (logical shift).
- Amount saturation: any in_amt ≥ WIDTH executes exactly WIDTH steps, so out_data=0.
- The counter never wraps. cnt is AW bits wide and is only decremented in SHIFT with cnt≥1.

## Timing
- Reset values:
  - state=IDLE, data_q=0, last_q=0, cnt=0, dir_q=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
- Latency: request accepted at the edge ending cycle t with effective count n. out_valid first high in cycle t+1+n.
- Throughput: one request per n+2 cycles minimum, with out_ready held high.
- Backpressure: out_valid stays high while out_ready=0, and out_data/out_last do not change. No timeout.
- After the handshake edge in DONE, in_ready=1 in the following cycle.
- Reset has priority over all events. rst asserted in any state (including mid-SHIFT or during DONE with out_ready=1) returns everything to reset values at that edge. The in-flight result is discarded.
- Simultaneous in_valid and rst: the request is not accepted.
- All outputs are driven from registers/state. There is no combinational path from in_* or out_ready to any output.

## Structure
- Package shift_seq_pkg contains:
  - state enum (IDLE, SHIFT, DONE).
  - direction constants DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
- One sub-module, shift_step:
  - Combinational single-bit logical shift of WIDTH bits, parameterised by WIDTH.
  - Inputs: operand and direction. Outputs: shifted word and shifted-out bit.
  - Instantiated once. Its output feeds data_q/last_q.
- The sequencer owns the FSM, counter, saturation logic and the handshake registers.

## Test plan
- Left by 2 (WIDTH=4): in_data=4'b1011, dir=0, amt=2 → out_data=4'b1100, out_last=0, out_valid first high at t+3.
- Right by 1: in_data=4'b1011, dir=1, amt=1 → out_data=4'b0101, out_last=1, out_valid at t+2.
- Zero amount: in_data=4'b1001, amt=0 → out_data=4'b1001, out_last=0, out_valid at t+1, no SHIFT cycle.
- Saturation: in_data=4'b0001, dir=0, amt=7 → exactly 4 SHIFT cycles, out_data=4'b0000, out_last=1, out_valid at t+5.
- Backpressure: hold out_ready=0 for 3 cycles in DONE.
  - out_data/out_last stay stable, in_ready=0, and a concurrent in_valid is ignored.
  - Raise out_ready → IDLE next cycle, in_ready=1.
- Reset mid-operation: amt=3, assert rst in the second SHIFT cycle → next cycle state IDLE with all outputs at reset values. A subsequent request runs normally.
